// File: rtl/am_query_arbiter.sv
// -----------------------------------------------------------------------------
// am_query_arbiter
//
// Shares one associative-memory (AM) search engine among several query
// sources (per-modality encoders, a test port, ...). One query is in flight at
// any time. The arbiter picks a requester round-robin, registers its query
// hypervector, drives the AM query handshake, waits for the AM result,
// registers it, and hands it back to the requester that issued the query.
// The number of cycles from query issue to result accept is kept for
// performance monitoring.
//
// Ports
//   Clk_CI             clock, rising edge
//   Reset_RBI          asynchronous active-low reset
//   ReqValid_SI        per-requester query valid
//   ReqReady_SO        per-requester query accepted (one-hot or zero)
//   ReqHypervector_DI  packed queries, requester i at [i*HV_DIMENSION +: HV_DIMENSION]
//   AmValid_SO         query valid towards the AM
//   AmReady_SI         AM ready to take a query
//   AmHypervector_DO   registered query towards the AM
//   AmValid_SI         AM result valid
//   AmReady_SO         arbiter ready to take an AM result
//   AmLabelA_DI/V_DI   AM result labels
//   AmDistA_DI/V_DI    AM result Hamming distances
//   RspValid_SO        per-requester result valid (one-hot or zero)
//   RspReady_SI        per-requester result ready
//   RspLabelA_DO/V_DO  shared result label bus
//   RspDistA_DO/V_DO   shared result distance bus
//   GrantId_DO         index of the requester currently owning the AM
//   Busy_SO            high whenever a transaction is in progress
//   LastLatency_DO     issue-to-result latency of the last completed search
// -----------------------------------------------------------------------------
module am_query_arbiter #(
   parameter int NUM_REQ        = 3,
   parameter int HV_DIMENSION   = 2000,
   parameter int LABEL_WIDTH    = 1,
   parameter int DISTANCE_WIDTH = 11,
   parameter int LAT_WIDTH      = 12,
   localparam int GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                             Clk_CI,
   input  logic                             Reset_RBI,
   input  logic [NUM_REQ-1:0]               ReqValid_SI,
   output logic [NUM_REQ-1:0]               ReqReady_SO,
   input  logic [NUM_REQ*HV_DIMENSION-1:0]  ReqHypervector_DI,
   output logic                             AmValid_SO,
   input  logic                             AmReady_SI,
   output logic [HV_DIMENSION-1:0]          AmHypervector_DO,
   input  logic                             AmValid_SI,
   output logic                             AmReady_SO,
   input  logic [LABEL_WIDTH-1:0]           AmLabelA_DI,
   input  logic [LABEL_WIDTH-1:0]           AmLabelV_DI,
   input  logic [DISTANCE_WIDTH-1:0]        AmDistA_DI,
   input  logic [DISTANCE_WIDTH-1:0]        AmDistV_DI,
   output logic [NUM_REQ-1:0]               RspValid_SO,
   input  logic [NUM_REQ-1:0]               RspReady_SI,
   output logic [LABEL_WIDTH-1:0]           RspLabelA_DO,
   output logic [LABEL_WIDTH-1:0]           RspLabelV_DO,
   output logic [DISTANCE_WIDTH-1:0]        RspDistA_DO,
   output logic [DISTANCE_WIDTH-1:0]        RspDistV_DO,
   output logic [GW-1:0]                    GrantId_DO,
   output logic                             Busy_SO,
   output logic [LAT_WIDTH-1:0]             LastLatency_DO
);

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StIssue   = 2'd1,
      StWait    = 2'd2,
      StRespond = 2'd3
   } state_t;

   localparam logic [GW-1:0]        PtrResetVal = GW'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0]   OneHotBase  = NUM_REQ'(1);
   localparam logic [LAT_WIDTH-1:0] LatOne      = LAT_WIDTH'(1);
   localparam logic [LAT_WIDTH-1:0] LatMax      = '1;

   state_t                    stateQ;
   logic [GW-1:0]             ptrQ;
   logic [GW-1:0]             grantIdQ;
   logic [HV_DIMENSION-1:0]   queryQ;
   logic [LABEL_WIDTH-1:0]    labelAQ;
   logic [LABEL_WIDTH-1:0]    labelVQ;
   logic [DISTANCE_WIDTH-1:0] distAQ;
   logic [DISTANCE_WIDTH-1:0] distVQ;
   logic [LAT_WIDTH-1:0]      latCntQ;
   logic [LAT_WIDTH-1:0]      lastLatQ;

   logic                      winFound;
   logic [GW-1:0]             winIdx;
   logic [GW-1:0]             candIdx;
   int                        candSum;
   logic [LAT_WIDTH-1:0]      latCntNext;
   logic [HV_DIMENSION-1:0]   winHypervector;

   // Round-robin search: start one past the last winner and wrap around, so
   // the requester granted last has the lowest priority next time. The index
   // sum never exceeds 2*NUM_REQ-1, so a single conditional subtract replaces
   // a modulo.
   always_comb begin
      winFound = 1'b0;
      winIdx   = '0;
      candIdx  = '0;
      candSum  = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         candSum = int'(ptrQ) + off;
         if (candSum >= NUM_REQ) begin
            candSum = candSum - NUM_REQ;
         end
         candIdx = GW'(candSum);
         if (!winFound && ReqValid_SI[candIdx]) begin
            winFound = 1'b1;
            winIdx   = candIdx;
         end
      end
   end

   // Query of the current winner, picked from the packed requester bus.
   always_comb begin
      winHypervector = ReqHypervector_DI[winIdx*HV_DIMENSION +: HV_DIMENSION];
   end

   // Latency counter saturates instead of wrapping so that a very slow search
   // still reports "at least the maximum" rather than a small bogus value.
   always_comb begin
      latCntNext = latCntQ;
      if (latCntQ != LatMax) begin
         latCntNext = latCntQ + LatOne;
      end
   end

   // Handshake outputs are decoded from the registered state so that the AM
   // and the requesters see them in the same cycle the state is entered.
   // ReqReady additionally follows ReqValid so a grant is visible in the very
   // cycle it is decided.
   always_comb begin
      ReqReady_SO = '0;
      RspValid_SO = '0;
      if ((stateQ == StIdle) && winFound) begin
         ReqReady_SO = OneHotBase << winIdx;
      end
      if (stateQ == StRespond) begin
         RspValid_SO = OneHotBase << grantIdQ;
      end
      AmValid_SO = (stateQ == StIssue);
      AmReady_SO = (stateQ == StWait);
      Busy_SO    = (stateQ != StIdle);
   end

   // Transaction FSM together with every data register. Reset at any point
   // abandons the running transaction and returns priority to requester 0.
   // AM inputs are only looked at in the state that owns the respective
   // handshake, so stray pulses elsewhere cannot disturb the held result.
   always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
      if (!Reset_RBI) begin
         stateQ   <= StIdle;
         ptrQ     <= PtrResetVal;
         grantIdQ <= '0;
         queryQ   <= '0;
         labelAQ  <= '0;
         labelVQ  <= '0;
         distAQ   <= '0;
         distVQ   <= '0;
         latCntQ  <= '0;
         lastLatQ <= '0;
      end else begin
         case (stateQ)
            StIdle: begin
               if (winFound) begin
                  queryQ   <= winHypervector;
                  grantIdQ <= winIdx;
                  ptrQ     <= winIdx;
                  latCntQ  <= LatOne;
                  stateQ   <= StIssue;
               end
            end
            StIssue: begin
               latCntQ <= latCntNext;
               if (AmReady_SI) begin
                  stateQ <= StWait;
               end
            end
            StWait: begin
               latCntQ <= latCntNext;
               if (AmValid_SI) begin
                  labelAQ  <= AmLabelA_DI;
                  labelVQ  <= AmLabelV_DI;
                  distAQ   <= AmDistA_DI;
                  distVQ   <= AmDistV_DI;
                  lastLatQ <= latCntQ;
                  stateQ   <= StRespond;
               end
            end
            StRespond: begin
               if (RspReady_SI[grantIdQ]) begin
                  stateQ <= StIdle;
               end
            end
            default: begin
               stateQ <= StIdle;
            end
         endcase
      end
   end

   assign AmHypervector_DO = queryQ;
   assign RspLabelA_DO     = labelAQ;
   assign RspLabelV_DO     = labelVQ;
   assign RspDistA_DO      = distAQ;
   assign RspDistV_DO      = distVQ;
   assign GrantId_DO       = grantIdQ;
   assign LastLatency_DO   = lastLatQ;

endmodule

// File: tb/tb_am_query_arbiter.sv
// -----------------------------------------------------------------------------
// tb_am_query_arbiter
//
// Directed bench for am_query_arbiter with three requesters. Inputs are
// driven 1 time unit after the rising edge and outputs are sampled there too.
// Each scenario task checks its own expectations inline.
// -----------------------------------------------------------------------------
module tb_am_query_arbiter;

   localparam int NR  = 3;
   localparam int HV  = 2000;
   localparam int LW  = 1;
   localparam int DW  = 11;
   localparam int LTW = 12;
   localparam int GW  = 2;

   logic              Clk_CI;
   logic              Reset_RBI;
   logic [NR-1:0]     ReqValid_SI;
   logic [NR-1:0]     ReqReady_SO;
   logic [NR*HV-1:0]  ReqHypervector_DI;
   logic              AmValid_SO;
   logic              AmReady_SI;
   logic [HV-1:0]     AmHypervector_DO;
   logic              AmValid_SI;
   logic              AmReady_SO;
   logic [LW-1:0]     AmLabelA_DI;
   logic [LW-1:0]     AmLabelV_DI;
   logic [DW-1:0]     AmDistA_DI;
   logic [DW-1:0]     AmDistV_DI;
   logic [NR-1:0]     RspValid_SO;
   logic [NR-1:0]     RspReady_SI;
   logic [LW-1:0]     RspLabelA_DO;
   logic [LW-1:0]     RspLabelV_DO;
   logic [DW-1:0]     RspDistA_DO;
   logic [DW-1:0]     RspDistV_DO;
   logic [GW-1:0]     GrantId_DO;
   logic              Busy_SO;
   logic [LTW-1:0]    LastLatency_DO;

   logic [HV-1:0]     pat [NR];
   int                passCount;
   int                checkCount;

   am_query_arbiter #(
      .NUM_REQ        (NR),
      .HV_DIMENSION   (HV),
      .LABEL_WIDTH    (LW),
      .DISTANCE_WIDTH (DW),
      .LAT_WIDTH      (LTW)
   ) dut (
      .Clk_CI            (Clk_CI),
      .Reset_RBI         (Reset_RBI),
      .ReqValid_SI       (ReqValid_SI),
      .ReqReady_SO       (ReqReady_SO),
      .ReqHypervector_DI (ReqHypervector_DI),
      .AmValid_SO        (AmValid_SO),
      .AmReady_SI        (AmReady_SI),
      .AmHypervector_DO  (AmHypervector_DO),
      .AmValid_SI        (AmValid_SI),
      .AmReady_SO        (AmReady_SO),
      .AmLabelA_DI       (AmLabelA_DI),
      .AmLabelV_DI       (AmLabelV_DI),
      .AmDistA_DI        (AmDistA_DI),
      .AmDistV_DI        (AmDistV_DI),
      .RspValid_SO       (RspValid_SO),
      .RspReady_SI       (RspReady_SI),
      .RspLabelA_DO      (RspLabelA_DO),
      .RspLabelV_DO      (RspLabelV_DO),
      .RspDistA_DO       (RspDistA_DO),
      .RspDistV_DO       (RspDistV_DO),
      .GrantId_DO        (GrantId_DO),
      .Busy_SO           (Busy_SO),
      .LastLatency_DO    (LastLatency_DO)
   );

   // Free-running clock, period 10.
   initial begin
      Clk_CI = 1'b0;
      forever #5 Clk_CI = ~Clk_CI;
   end

   // Safety net so the run always ends.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge Clk_CI);
      #1;
   endtask

   task automatic pulseReset();
      Reset_RBI = 1'b0;
      tick();
      Reset_RBI = 1'b1;
   endtask

   // Called in the first WAIT cycle; the result is taken at the edge that
   // lies 'delay' cycles after the AM accepted the query.
   task automatic amResult(input int delay, input logic [LW-1:0] la, input logic [LW-1:0] lv,
                           input logic [DW-1:0] da, input logic [DW-1:0] dv);
      repeat (delay - 1) tick();
      AmValid_SI  = 1'b1;
      AmLabelA_DI = la;
      AmLabelV_DI = lv;
      AmDistA_DI  = da;
      AmDistV_DI  = dv;
      tick();
      AmValid_SI  = 1'b0;
      AmLabelA_DI = '0;
      AmLabelV_DI = '0;
      AmDistA_DI  = '0;
      AmDistV_DI  = '0;
   endtask

   task automatic test_reset();
      Reset_RBI = 1'b0;
      tick();
      tick();
      checkCount++; if (Busy_SO !== 1'b0) $display("[TB] FAIL rst_busy: got %0b want 0", Busy_SO); else passCount++;
      checkCount++; if (AmValid_SO !== 1'b0) $display("[TB] FAIL rst_amvalid: got %0b want 0", AmValid_SO); else passCount++;
      checkCount++; if (AmReady_SO !== 1'b0) $display("[TB] FAIL rst_amready: got %0b want 0", AmReady_SO); else passCount++;
      checkCount++; if (RspValid_SO !== 3'b000) $display("[TB] FAIL rst_rspvalid: got %0b want 000", RspValid_SO); else passCount++;
      checkCount++; if (ReqReady_SO !== 3'b000) $display("[TB] FAIL rst_reqready: got %0b want 000", ReqReady_SO); else passCount++;
      checkCount++; if (GrantId_DO !== 2'd0) $display("[TB] FAIL rst_grant: got %0d want 0", GrantId_DO); else passCount++;
      checkCount++; if (LastLatency_DO !== 12'd0) $display("[TB] FAIL rst_latency: got %0d want 0", LastLatency_DO); else passCount++;
      checkCount++; if (AmHypervector_DO !== '0) $display("[TB] FAIL rst_amhv: low word got %0h want 0", AmHypervector_DO[31:0]); else passCount++;
      checkCount++; if (RspDistA_DO !== 11'd0 || RspDistV_DO !== 11'd0) $display("[TB] FAIL rst_rspdist: got %0d/%0d want 0/0", RspDistA_DO, RspDistV_DO); else passCount++;
      Reset_RBI = 1'b1;
   endtask

   task automatic test_single();
      ReqValid_SI = 3'b010;
      AmReady_SI  = 1'b1;
      #1;
      checkCount++; if (ReqReady_SO !== 3'b010) $display("[TB] FAIL single_reqready: got %0b want 010", ReqReady_SO); else passCount++;
      tick();
      ReqValid_SI = 3'b000;
      checkCount++; if (ReqReady_SO !== 3'b000) $display("[TB] FAIL single_reqready_once: got %0b want 000", ReqReady_SO); else passCount++;
      checkCount++; if (AmValid_SO !== 1'b1) $display("[TB] FAIL single_amvalid: got %0b want 1", AmValid_SO); else passCount++;
      checkCount++; if (GrantId_DO !== 2'd1) $display("[TB] FAIL single_grant: got %0d want 1", GrantId_DO); else passCount++;
      checkCount++; if (AmHypervector_DO !== pat[1]) $display("[TB] FAIL single_amhv: low word got %0h want %0h", AmHypervector_DO[31:0], pat[1][31:0]); else passCount++;
      tick();
      AmReady_SI = 1'b0;
      checkCount++; if (AmReady_SO !== 1'b1) $display("[TB] FAIL single_amready: got %0b want 1", AmReady_SO); else passCount++;
      amResult(20, 1'b1, 1'b0, 11'd400, 11'd17);
      checkCount++; if (RspValid_SO !== 3'b010) $display("[TB] FAIL single_rspvalid: got %0b want 010", RspValid_SO); else passCount++;
      checkCount++; if (RspLabelA_DO !== 1'b1) $display("[TB] FAIL single_labela: got %0d want 1", RspLabelA_DO); else passCount++;
      checkCount++; if (RspDistA_DO !== 11'd400) $display("[TB] FAIL single_dista: got %0d want 400", RspDistA_DO); else passCount++;
      checkCount++; if (RspDistV_DO !== 11'd17) $display("[TB] FAIL single_distv: got %0d want 17", RspDistV_DO); else passCount++;
      checkCount++; if (LastLatency_DO !== 12'd21) $display("[TB] FAIL single_latency: got %0d want 21", LastLatency_DO); else passCount++;
      RspReady_SI = 3'b010;
      tick();
      RspReady_SI = 3'b000;
      checkCount++; if (Busy_SO !== 1'b0) $display("[TB] FAIL single_idle: busy got %0b want 0", Busy_SO); else passCount++;
   endtask

   task automatic test_round_robin();
      logic [NR-1:0] expOh;
      int            expId;
      logic [DW-1:0] expDist;
      ReqValid_SI = 3'b111;
      pulseReset();
      for (int i = 0; i < 4; i++) begin
         expId   = i % NR;
         expOh   = NR'(1 << expId);
         expDist = DW'(100 + 10 * expId + i);
         checkCount++; if (ReqReady_SO !== expOh) $display("[TB] FAIL rr_reqready[%0d]: got %0b want %0b", i, ReqReady_SO, expOh); else passCount++;
         tick();
         checkCount++; if (GrantId_DO !== GW'(expId)) $display("[TB] FAIL rr_grant[%0d]: got %0d want %0d", i, GrantId_DO, expId); else passCount++;
         checkCount++; if (AmHypervector_DO !== pat[expId]) $display("[TB] FAIL rr_amhv[%0d]: low word got %0h want %0h", i, AmHypervector_DO[31:0], pat[expId][31:0]); else passCount++;
         AmReady_SI = 1'b1;
         tick();
         AmReady_SI = 1'b0;
         amResult(3, LW'(expId & 1), LW'(~expId & 1), expDist, DW'(5 + i));
         checkCount++; if (RspValid_SO !== expOh || RspDistA_DO !== expDist) $display("[TB] FAIL rr_rsp[%0d]: got valid %0b dist %0d want %0b %0d", i, RspValid_SO, RspDistA_DO, expOh, expDist); else passCount++;
         RspReady_SI = 3'b111;
         tick();
         RspReady_SI = 3'b000;
      end
      ReqValid_SI = 3'b000;
   endtask

   task automatic test_skip_order();
      pulseReset();
      ReqValid_SI = 3'b010;
      #1;
      tick();
      ReqValid_SI = 3'b101;
      checkCount++; if (GrantId_DO !== 2'd1) $display("[TB] FAIL skip_first: got %0d want 1", GrantId_DO); else passCount++;
      AmReady_SI = 1'b1;
      tick();
      AmReady_SI = 1'b0;
      amResult(1, 1'b0, 1'b0, 11'd10, 11'd11);
      RspReady_SI = 3'b010;
      tick();
      RspReady_SI = 3'b000;
      checkCount++; if (ReqReady_SO !== 3'b100) $display("[TB] FAIL skip_reqready2: got %0b want 100", ReqReady_SO); else passCount++;
      tick();
      checkCount++; if (GrantId_DO !== 2'd2) $display("[TB] FAIL skip_grant2: got %0d want 2", GrantId_DO); else passCount++;
      AmReady_SI = 1'b1;
      tick();
      AmReady_SI = 1'b0;
      amResult(1, 1'b0, 1'b0, 11'd12, 11'd13);
      RspReady_SI = 3'b100;
      tick();
      RspReady_SI = 3'b000;
      checkCount++; if (ReqReady_SO !== 3'b001) $display("[TB] FAIL skip_reqready0: got %0b want 001", ReqReady_SO); else passCount++;
      ReqValid_SI = 3'b000;
   endtask

   task automatic test_issue_stall();
      ReqValid_SI = 3'b001;
      AmReady_SI  = 1'b0;
      #1;
      tick();
      ReqValid_SI = 3'b000;
      for (int j = 0; j < 5; j++) begin
         checkCount++; if (AmValid_SO !== 1'b1) $display("[TB] FAIL stall_amvalid[%0d]: got %0b want 1", j, AmValid_SO); else passCount++;
         checkCount++; if (AmHypervector_DO !== pat[0]) $display("[TB] FAIL stall_amhv[%0d]: low word got %0h want %0h", j, AmHypervector_DO[31:0], pat[0][31:0]); else passCount++;
         AmValid_SI = (j == 2);
         AmDistA_DI = (j == 2) ? 11'd777 : 11'd0;
         tick();
      end
      AmValid_SI = 1'b0;
      AmDistA_DI = '0;
      AmReady_SI = 1'b1;
      tick();
      AmReady_SI = 1'b0;
      amResult(2, 1'b0, 1'b1, 11'd55, 11'd66);
      checkCount++; if (RspDistA_DO !== 11'd55) $display("[TB] FAIL stall_dista: got %0d want 55", RspDistA_DO); else passCount++;
      checkCount++; if (RspLabelV_DO !== 1'b1) $display("[TB] FAIL stall_labelv: got %0d want 1", RspLabelV_DO); else passCount++;
      checkCount++; if (LastLatency_DO !== 12'd8) $display("[TB] FAIL stall_latency: got %0d want 8", LastLatency_DO); else passCount++;
   endtask

   // Continues from the RESPOND state left behind by test_issue_stall.
   task automatic test_rsp_stall();
      RspReady_SI = 3'b110;
      ReqValid_SI = 3'b110;
      for (int j = 0; j < 10; j++) begin
         checkCount++; if (RspValid_SO !== 3'b001 || RspDistA_DO !== 11'd55 || RspDistV_DO !== 11'd66) $display("[TB] FAIL rspstall_hold[%0d]: got %0b %0d %0d want 001 55 66", j, RspValid_SO, RspDistA_DO, RspDistV_DO); else passCount++;
         checkCount++; if (ReqReady_SO !== 3'b000) $display("[TB] FAIL rspstall_reqready[%0d]: got %0b want 000", j, ReqReady_SO); else passCount++;
         tick();
      end
      RspReady_SI = 3'b001;
      tick();
      RspReady_SI = 3'b000;
      checkCount++; if (Busy_SO !== 1'b0) $display("[TB] FAIL rspstall_idle: busy got %0b want 0", Busy_SO); else passCount++;
      checkCount++; if (ReqReady_SO !== 3'b010) $display("[TB] FAIL rspstall_next: got %0b want 010", ReqReady_SO); else passCount++;
      ReqValid_SI = 3'b000;
   endtask

   task automatic test_reset_abort();
      ReqValid_SI = 3'b100;
      #1;
      tick();
      ReqValid_SI = 3'b000;
      AmReady_SI  = 1'b1;
      tick();
      AmReady_SI  = 1'b0;
      tick();
      tick();
      Reset_RBI = 1'b0;
      #1;
      checkCount++; if (Busy_SO !== 1'b0 || AmReady_SO !== 1'b0) $display("[TB] FAIL abort_state: busy %0b amready %0b want 0 0", Busy_SO, AmReady_SO); else passCount++;
      checkCount++; if (GrantId_DO !== 2'd0) $display("[TB] FAIL abort_grant: got %0d want 0", GrantId_DO); else passCount++;
      checkCount++; if (LastLatency_DO !== 12'd0) $display("[TB] FAIL abort_latency: got %0d want 0", LastLatency_DO); else passCount++;
      checkCount++; if (AmHypervector_DO !== '0) $display("[TB] FAIL abort_amhv: low word got %0h want 0", AmHypervector_DO[31:0]); else passCount++;
      tick();
      Reset_RBI   = 1'b1;
      AmValid_SI  = 1'b1;
      AmDistA_DI  = 11'd999;
      AmLabelA_DI = 1'b1;
      tick();
      AmValid_SI  = 1'b0;
      AmDistA_DI  = '0;
      AmLabelA_DI = '0;
      checkCount++; if (RspValid_SO !== 3'b000) $display("[TB] FAIL abort_rspvalid: got %0b want 000", RspValid_SO); else passCount++;
      checkCount++; if (RspDistA_DO !== 11'd0 || RspLabelA_DO !== 1'b0) $display("[TB] FAIL abort_rspbus: got %0d/%0d want 0/0", RspDistA_DO, RspLabelA_DO); else passCount++;
      ReqValid_SI = 3'b111;
      #1;
      checkCount++; if (ReqReady_SO !== 3'b001) $display("[TB] FAIL abort_nextgrant: got %0b want 001", ReqReady_SO); else passCount++;
      ReqValid_SI = 3'b000;
   endtask

   task automatic test_latency_saturation();
      ReqValid_SI = 3'b001;
      #1;
      tick();
      ReqValid_SI = 3'b000;
      AmReady_SI  = 1'b1;
      tick();
      AmReady_SI  = 1'b0;
      amResult(5000, 1'b1, 1'b1, 11'd2047, 11'd1);
      checkCount++; if (LastLatency_DO !== 12'd4095) $display("[TB] FAIL sat_latency: got %0d want 4095", LastLatency_DO); else passCount++;
      checkCount++; if (RspValid_SO !== 3'b001 || RspDistA_DO !== 11'd2047) $display("[TB] FAIL sat_rsp: got %0b %0d want 001 2047", RspValid_SO, RspDistA_DO); else passCount++;
      RspReady_SI = 3'b001;
      tick();
      RspReady_SI = 3'b000;
      checkCount++; if (Busy_SO !== 1'b0) $display("[TB] FAIL sat_idle: busy got %0b want 0", Busy_SO); else passCount++;
   endtask

   // Scenario sequence; later tasks rely on the state earlier ones leave.
   initial begin
      passCount   = 0;
      checkCount  = 0;
      pat[0]      = {250{8'h3C}};
      pat[1]      = {250{8'hA5}};
      pat[2]      = {250{8'h96}};
      Reset_RBI   = 1'b0;
      ReqValid_SI = '0;
      RspReady_SI = '0;
      AmReady_SI  = 1'b0;
      AmValid_SI  = 1'b0;
      AmLabelA_DI = '0;
      AmLabelV_DI = '0;
      AmDistA_DI  = '0;
      AmDistV_DI  = '0;
      for (int i = 0; i < NR; i++) begin
         ReqHypervector_DI[i*HV +: HV] = pat[i];
      end
      test_reset();
      test_single();
      test_round_robin();
      test_skip_order();
      test_issue_stall();
      test_rsp_stall();
      test_reset_abort();
      test_latency_saturation();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
